cfo_phase_align: RTL
====================

Name: cfo_phase_align

Overview:
Multi-channel successor to the receiver's CFO phase accumulator and fixed 14-deep alignment delay line. Accepts relative or absolute CFO updates from the PSS detector and produces a per-sample wrapped DDS phase word. It also delays NUM_CH parallel sample lanes by a runtime-programmable cycle count, so that frame_sync and FFT_demod see data aligned to detector decisions. Sits between the input FIFO and the DDS/complex-multiplier chain, and feeds the frame_sync input path.

Parameters:
IN_DW, 32, width of one complex sample per channel (I in low half, Q in high half)
NUM_CH, 1, number of parallel antenna lanes sharing one tvalid
PHASE_DW, 20, DDS phase word width
CFO_DW, 20, signed CFO increment width; must be <= PHASE_DW
MAX_DELAY, 32, maximum alignment delay in clock cycles; must be >= 2

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
s_axis_in_tdata  in  NUM_CH*IN_DW  channel c occupies bits [c*IN_DW +: IN_DW]
s_axis_in_tvalid  in  1  input sample valid
cfo_inc_i  in  CFO_DW  signed CFO increment from the PSS detector
cfo_valid_i  in  1  strobe; apply cfo_inc_i
cfo_mode_i  in  1  0 = relative update, 1 = absolute update
phase_sync_i  in  1  clear the phase accumulator
delay_i  in  $clog2(MAX_DELAY+1)  requested alignment delay in cycles
delay_we_i  in  1  strobe; load delay_i
m_axis_phase_tdata  out  PHASE_DW  phase word for the DDS
m_axis_phase_tvalid  out  1  phase valid
m_axis_out_tdata  out  NUM_CH*IN_DW  delayed samples
m_axis_out_tvalid  out  1  delayed valid
cfo_inc_o  out  PHASE_DW  current effective increment (signed)
delay_busy_o  out  1  high while the delay line is flushing

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Clock port is clk_i, reset port is reset_i.
- No tready anywhere; the block always accepts data.

Reset:
- All outputs are 0.
- Effective increment is 0, phase accumulator is 0, delay is MAX_DELAY.
- All delay-line valid bits are cleared. Data contents are don't-care but are zeroed.

CFO increment register (inc, PHASE_DW bits, signed):
- cfo_inc_i is sign-extended to PHASE_DW.
- On cfo_valid_i with cfo_mode_i=0: inc <= inc - ext(cfo_inc_i).
- On cfo_valid_i with cfo_mode_i=1: inc <= -ext(cfo_inc_i).
- Arithmetic wraps modulo 2^PHASE_DW, with no saturation.
- cfo_inc_o = inc, registered. The new value appears the cycle after the strobe.

Phase accumulator:
- On s_axis_in_tvalid: acc <= acc + inc, wrapping modulo 2^PHASE_DW.
- m_axis_phase_tdata <= the new acc and m_axis_phase_tvalid <= 1, giving 1-cycle latency. Otherwise m_axis_phase_tvalid <= 0 and the data holds.
- If cfo_valid_i and s_axis_in_tvalid arrive in the same cycle, the sample uses the OLD inc.
- phase_sync_i has priority over accumulation: acc <= 0. If tvalid is also high, the output phase is 0 and the next sample uses 0 + inc.

Alignment delay:
- Circular buffer of MAX_DELAY entries, each {tvalid, tdata}, written every cycle. This counts clock cycles, not samples, matching the existing fixed line.
- Read pointer = write pointer - D (mod MAX_DELAY). Output is registered, so total latency is exactly D cycles from input to m_axis_out_*.

Programming the delay:
- delay_we_i loads D.
- delay_i = 0 is treated as 1; delay_i > MAX_DELAY is clamped to MAX_DELAY.
- A change of D sets a flush counter to D. While it is non-zero, m_axis_out_tvalid is forced to 0 and delay_busy_o = 1.
- delay_we_i during a flush restarts the counter with the new D.
- delay_we_i with D unchanged is a no-op: no flush.
- Pointer wrap is seamless at index MAX_DELAY-1 to 0.

Reset during operation:
- All in-flight samples are dropped.
- The first valid output after reset appears MAX_DELAY cycles after the first valid input.

Decomposition:
- Package cfo_phase_align_pkg: the delay-clamp function, localparam DELAY_W = $clog2(MAX_DELAY+1), and the lane slicing helper.
- One sub-module, axis_var_delay: the circular buffer, read pointer and flush counter. The top level holds the CFO/phase logic and instantiates the delay for NUM_CH*IN_DW data plus the valid bit.

Test Plan:
1. Reset, then PHASE_DW=20, absolute cfo_inc_i=-1000 with cfo_mode_i=1, then 4 consecutive valid samples -> cfo_inc_o=1000; phase outputs 1000, 2000, 3000, 4000, each 1 cycle after its input.
2. Relative updates: inc=1000, then cfo_inc_i=+200 with mode 0 -> inc=800. A strobe coincident with a sample: that sample still adds 1000.
3. Wrap: inc=0x40000, 4 samples from acc=0xC0000 -> outputs 0x00000, 0x40000, 0x80000, 0xC0000.
4. phase_sync_i together with tvalid while acc=0x12345 -> phase output 0; the next sample outputs inc.
5. NUM_CH=2, D=14, counting pattern on both lanes -> each lane reproduced exactly 14 cycles later with tvalid gaps preserved. Then set D=5 mid-stream -> tvalid low for 5 cycles, delay_busy_o high, then 5-cycle latency.
6. delay_i=0 gives D=1; delay_i=MAX_DELAY+3 gives D=MAX_DELAY. Reset asserted mid-stream -> outputs 0 the next cycle and no stale samples emerge afterwards.

Source files
------------

// File: rtl/cfo_phase_align_pkg.sv
// Shared helpers for the CFO phase accumulator and alignment delay.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package cfo_phase_align_pkg;

  // Bit width that can hold every delay value 0..max_d inclusive.
  function automatic int delay_width(input int max_d);
    return $clog2(max_d + 1);
  endfunction

  // Map a requested delay onto the legal range 1..max_d.
  // A zero delay would read the slot being written this cycle, so it becomes 1.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_d);
    if (req == 0) begin
      return 1;
    end else if (req > max_d) begin
      return max_d;
    end else begin
      return req;
    end
  endfunction

  // LSB position of lane 'lane' in a packed multi-lane bus of 'dw'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/axis_var_delay.sv
// Runtime-programmable delay line for a {valid, data} stream, counted in clock cycles.
// Latency: exactly D cycles input to output, D in 1..MAX_DELAY.
// Backpressure: none; written every cycle, valid is masked while a delay change flushes.
module axis_var_delay
  import cfo_phase_align_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MAX_DELAY = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [DW-1:0]                    in_dat,
  input  logic                             in_vld,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   delay_i,
  input  logic                             delay_we_i,
  output logic [DW-1:0]                    out_dat,
  output logic                             out_vld,
  output logic                             busy
);

  localparam int DLY_W = delay_width(MAX_DELAY);
  localparam int PTR_W = $clog2(MAX_DELAY);

  // Each slot stores {valid, data}; valid sits in the top bit.
  logic [DW:0]      mem_q [MAX_DELAY];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] flush_q;
  logic [DLY_W-1:0] new_dly;
  logic [DW:0]      out_q;
  int               rd_idx;

  // Clamp the requested delay into 1..MAX_DELAY.
  always_comb begin
    new_dly = DLY_W'(clamp_delay(32'(delay_i), 32'(MAX_DELAY)));
  end

  // Read slot sits D-1 entries behind the write slot; the output register adds
  // the final cycle. Wrap is done by a single conditional subtract so any
  // MAX_DELAY works, not only powers of two.
  always_comb begin
    rd_idx = int'(wr_ptr) + MAX_DELAY - (int'(dly_q) - 1);
    if (rd_idx >= MAX_DELAY) begin
      rd_idx = rd_idx - MAX_DELAY;
    end
    rd_ptr = PTR_W'(rd_idx);
  end

  // Circular buffer write and write-pointer advance; reset drops all in-flight entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr <= '0;
    end else begin
      mem_q[wr_ptr] <= {in_vld, in_dat};
      if (wr_ptr == PTR_W'(MAX_DELAY - 1)) begin
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Output register; D=1 bypasses the buffer because the read slot would be
  // the one being written in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_q <= '0;
    end else if (dly_q == DLY_W'(1)) begin
      out_q <= {in_vld, in_dat};
    end else begin
      out_q <= mem_q[rd_ptr];
    end
  end

  // Delay register and flush counter. A real change of D starts a D-cycle
  // flush so no sample ever emerges with the wrong latency; rewriting the same
  // D leaves the stream untouched.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dly_q   <= DLY_W'(MAX_DELAY);
      flush_q <= '0;
    end else if (delay_we_i && (new_dly != dly_q)) begin
      dly_q   <= new_dly;
      flush_q <= new_dly;
    end else if (flush_q != '0) begin
      flush_q <= flush_q - 1'b1;
    end
  end

  assign busy    = (flush_q != '0);
  assign out_dat = out_q[DW-1:0];
  assign out_vld = out_q[DW] & ~busy;

endmodule

// File: rtl/cfo_phase_align.sv
// CFO increment register, wrapped DDS phase accumulator and multi-lane alignment delay.
// Latency: phase 1 cycle after each valid sample; samples delayed by programmable D cycles.
// Backpressure: none; every input is accepted every cycle (no tready).
module cfo_phase_align
  import cfo_phase_align_pkg::*;
#(
  parameter int IN_DW     = 32,
  parameter int NUM_CH    = 1,
  parameter int PHASE_DW  = 20,
  parameter int CFO_DW    = 20,   // must not exceed PHASE_DW
  parameter int MAX_DELAY = 32    // must be at least 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_CH*IN_DW-1:0]          s_axis_in_tdata,
  input  logic                             s_axis_in_tvalid,
  input  logic [CFO_DW-1:0]                cfo_inc_i,
  input  logic                             cfo_valid_i,
  input  logic                             cfo_mode_i,
  input  logic                             phase_sync_i,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   delay_i,
  input  logic                             delay_we_i,
  output logic [PHASE_DW-1:0]              m_axis_phase_tdata,
  output logic                             m_axis_phase_tvalid,
  output logic [NUM_CH*IN_DW-1:0]          m_axis_out_tdata,
  output logic                             m_axis_out_tvalid,
  output logic [PHASE_DW-1:0]              cfo_inc_o,
  output logic                             delay_busy_o
);

  localparam int DATA_W = NUM_CH * IN_DW;

  logic signed [PHASE_DW-1:0] cfo_ext;
  logic        [PHASE_DW-1:0] inc_q;
  logic        [PHASE_DW-1:0] acc_q;
  logic        [PHASE_DW-1:0] acc_next;
  logic        [PHASE_DW-1:0] phase_q;
  logic                       phase_vld_q;

  // Detector increments are signed; widen with sign extension before use.
  assign cfo_ext  = PHASE_DW'($signed(cfo_inc_i));
  assign acc_next = acc_q + inc_q;

  // Effective increment: the detector reports the offset to remove, hence the
  // negation in both modes. Arithmetic wraps; no saturation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inc_q <= '0;
    end else if (cfo_valid_i) begin
      if (cfo_mode_i) begin
        inc_q <= -cfo_ext;
      end else begin
        inc_q <= inc_q - cfo_ext;
      end
    end
  end

  // Phase accumulator; a sample arriving with a CFO strobe still uses the old
  // increment because inc_q only changes at this same edge. Sync wins over
  // accumulation and yields a zero phase for a coincident sample.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q       <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
    end else begin
      phase_vld_q <= s_axis_in_tvalid;
      if (phase_sync_i) begin
        acc_q <= '0;
        if (s_axis_in_tvalid) begin
          phase_q <= '0;
        end
      end else if (s_axis_in_tvalid) begin
        acc_q   <= acc_next;
        phase_q <= acc_next;
      end
    end
  end

  assign m_axis_phase_tdata  = phase_q;
  assign m_axis_phase_tvalid = phase_vld_q;
  assign cfo_inc_o           = inc_q;

  // All lanes share one valid, so the whole packed bus travels as one entry.
  axis_var_delay #(
    .DW        (DATA_W),
    .MAX_DELAY (MAX_DELAY)
  ) u_delay (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .in_dat     (s_axis_in_tdata),
    .in_vld     (s_axis_in_tvalid),
    .delay_i    (delay_i),
    .delay_we_i (delay_we_i),
    .out_dat    (m_axis_out_tdata),
    .out_vld    (m_axis_out_tvalid),
    .busy       (delay_busy_o)
  );

endmodule
